// File: rtl/recv_pkg.sv
// -----------------------------------------------------------------------------
// recv_pkg
// Shared definitions for the receive PHY deframer and its CRC checker:
//   - rx_state_e     : deframer FSM states
//   - nibble markers : preamble and start-of-frame-delimiter nibbles
//   - CRC constants  : reflected polynomial, init value, good-frame residue
//   - ctrl block     : field indices of the two length fields (shared with xmit)
//   - bit_reverse32  : helper to compare the reflected CRC against the residue
// -----------------------------------------------------------------------------
package recv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    DATA = 2'd2,
    DROP = 2'd3
  } rx_state_e;

  localparam logic [3:0]  PREAMBLE_NIB  = 4'h5;
  localparam logic [3:0]  SFD_NIB       = 4'hD;

  // CRC-32, polynomial 04C11DB7 processed LSB-first (reflected form EDB88320).
  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  // Residue of a frame with a correct FCS, in normal (non-reflected) bit order.
  localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;

  // Control block = two length fields of LEN_W bits each.
  // Field k occupies bits [k*LEN_W +: LEN_W].
  localparam int CTRL_LEN_A_IDX = 0;
  localparam int CTRL_LEN_B_IDX = 1;
  localparam int CTRL_FIELDS    = 2;

  function automatic logic [31:0] bit_reverse32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

endpackage

// File: rtl/recv_phy_deframer_if.sv
// -----------------------------------------------------------------------------
// recv_phy_deframer_if
// Bundles the PHY-side receive pins and the deframer's byte/control outputs.
//   phy_rx_dv, phy_rx_er, phy_data_in : from PHY (driven by master)
//   r_data_out, r_data_valid          : assembled byte stream (driven by slave)
//   r_ctrl_out, r_frame_valid         : {len,len} control block + accept strobe
//   r_discard_en                      : reject strobe
// Modports:
//   master : PHY / environment side
//   slave  : deframer side
// -----------------------------------------------------------------------------
interface recv_phy_deframer_if #(
  parameter int LEN_W = 12
);

  logic               phy_rx_dv;
  logic               phy_rx_er;
  logic [3:0]         phy_data_in;

  logic [7:0]         r_data_out;
  logic               r_data_valid;
  logic [2*LEN_W-1:0] r_ctrl_out;
  logic               r_frame_valid;
  logic               r_discard_en;

  modport master (
    output phy_rx_dv, phy_rx_er, phy_data_in,
    input  r_data_out, r_data_valid, r_ctrl_out, r_frame_valid, r_discard_en
  );

  modport slave (
    input  phy_rx_dv, phy_rx_er, phy_data_in,
    output r_data_out, r_data_valid, r_ctrl_out, r_frame_valid, r_discard_en
  );

endinterface

// File: rtl/recv_crc32.sv
// -----------------------------------------------------------------------------
// recv_crc32
// Byte-wide CRC-32 (reflected, init FFFFFFFF) with a registered state.
// Ports:
//   clk_phy      in  PHY clock
//   reset        in  synchronous active-low reset
//   init_i       in  reload CRC_INIT (held while the deframer is idle)
//   en_i         in  fold byte_i into the CRC this cycle
//   byte_i       in  data byte
//   residue_ok_o out registered CRC equals the good-frame residue
// -----------------------------------------------------------------------------
module recv_crc32
  import recv_pkg::*;
(
  input  logic       clk_phy,
  input  logic       reset,
  input  logic       init_i,
  input  logic       en_i,
  input  logic [7:0] byte_i,
  output logic       residue_ok_o
);

  logic [31:0] crc_q;
  logic [31:0] crc_d;

  function automatic logic [31:0] crc32_next(input logic [31:0] crc,
                                             input logic [7:0]  data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

  always_comb begin
    // NOTE: default assignment first so every path drives crc_d -- no latch.
    crc_d = crc_q;
    if (init_i) begin
      crc_d = CRC_INIT;
    end else if (en_i) begin
      crc_d = crc32_next(crc_q, byte_i);
    end
  end

  always_ff @(posedge clk_phy) begin
    // NOTE: non-blocking for state so all flops update from pre-edge values.
    if (!reset) begin
      crc_q <= CRC_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  // The register holds the reflected CRC; flip it to compare with the residue.
  assign residue_ok_o = (bit_reverse32(crc_q) == CRC_RESIDUE);

endmodule

// File: rtl/recv_phy_deframer.sv
// -----------------------------------------------------------------------------
// recv_phy_deframer
// Receive-side deframer: strips preamble/SFD from the 4-bit PHY stream,
// assembles bytes low-nibble-first, counts the frame length and ends every
// tracked frame with either r_frame_valid (+ {len,len} control block) or
// r_discard_en.
// Ports:
//   clk_phy  in  PHY clock, sole clock
//   reset    in  synchronous active-low reset
//   bus      slave modport of recv_phy_deframer_if (PHY pins + outputs)
// Parameters:
//   LEN_W    length field width (saturating byte count)
//   MIN_LEN  smallest accepted frame (bytes after SFD)
//   MAX_LEN  largest accepted frame (bytes after SFD)
// Build option:
//   RECV_CRC_CHECK_EN  when defined, a CRC-32 over all bytes after SFD must
//                      match the good-frame residue for the frame to be
//                      accepted; otherwise the frame is discarded.
// -----------------------------------------------------------------------------
module recv_phy_deframer
  import recv_pkg::*;
#(
  parameter int LEN_W   = 12,
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 2048
) (
  input  logic                 clk_phy,
  input  logic                 reset,
  recv_phy_deframer_if.slave   bus
);

  localparam logic [LEN_W-1:0] MIN_L = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

  rx_state_e            state_q;
  logic                 phase_q;      // 0: expecting low nibble, 1: high nibble
  logic                 idle_seen_q;  // previous cycle had rx_dv low
  logic [3:0]           low_q;
  logic [LEN_W-1:0]     len_q;
  logic [LEN_W-1:0]     len_d;
  logic [7:0]           byte_d;
  logic [7:0]           data_q;
  logic                 data_valid_q;
  logic                 frame_valid_q;
  logic                 discard_q;
  logic [2*LEN_W-1:0]   ctrl_q;

  logic                 byte_take;
  logic                 len_ok;
  logic                 crc_ok;

  assign byte_d = {bus.phy_data_in, low_q};
  assign len_d  = (&len_q) ? len_q : len_q + LEN_W'(1);
  assign len_ok = (len_q >= MIN_L) && (len_q <= MAX_L);

  // A completed byte is only accepted while the frame is still within MAX_LEN;
  // the byte that would exceed it sends the FSM to DROP instead.
  assign byte_take = (state_q == DATA) && bus.phy_rx_dv && !bus.phy_rx_er &&
                     phase_q && (len_q < MAX_L);

`ifdef RECV_CRC_CHECK_EN
  recv_crc32 u_crc (
    .clk_phy      (clk_phy),
    .reset        (reset),
    .init_i       (state_q == IDLE),
    .en_i         (byte_take),
    .byte_i       (byte_d),
    .residue_ok_o (crc_ok)
  );
`else
  assign crc_ok = 1'b1;
`endif

  always_ff @(posedge clk_phy) begin
    if (!reset) begin
      state_q       <= IDLE;
      phase_q       <= 1'b0;
      idle_seen_q   <= 1'b0;
      low_q         <= '0;
      len_q         <= '0;
      data_q        <= '0;
      data_valid_q  <= 1'b0;
      frame_valid_q <= 1'b0;
      discard_q     <= 1'b0;
      ctrl_q        <= '0;
    end else begin
      // Strobes are single-cycle; ctrl is only non-zero alongside frame_valid.
      data_valid_q  <= 1'b0;
      frame_valid_q <= 1'b0;
      discard_q     <= 1'b0;
      ctrl_q        <= '0;
      idle_seen_q   <= !bus.phy_rx_dv;

      unique case (state_q)
        IDLE: begin
          // Only a fresh rx_dv rise starts a frame, so the tail of a frame
          // interrupted by reset is ignored.
          if (bus.phy_rx_dv && idle_seen_q) begin
            len_q   <= '0;
            phase_q <= 1'b0;
            state_q <= (bus.phy_data_in == PREAMBLE_NIB) ? PRE : DROP;
          end
        end

        PRE: begin
          if (!bus.phy_rx_dv) begin
            state_q <= IDLE;
          end else if (bus.phy_rx_er) begin
            state_q <= DROP;
          end else if (bus.phy_data_in == SFD_NIB) begin
            state_q <= DATA;
          end else if (bus.phy_data_in != PREAMBLE_NIB) begin
            state_q <= DROP;
          end
        end

        DATA: begin
          if (!bus.phy_rx_dv) begin
            state_q <= IDLE;
            if (!phase_q && len_ok && crc_ok) begin
              frame_valid_q <= 1'b1;
              ctrl_q[CTRL_LEN_A_IDX*LEN_W +: LEN_W] <= len_q;
              ctrl_q[CTRL_LEN_B_IDX*LEN_W +: LEN_W] <= len_q;
            end else begin
              discard_q <= 1'b1;
            end
          end else if (bus.phy_rx_er) begin
            state_q <= DROP;
          end else if (!phase_q) begin
            low_q   <= bus.phy_data_in;
            phase_q <= 1'b1;
          end else begin
            phase_q <= 1'b0;
            if (byte_take) begin
              data_q       <= byte_d;
              data_valid_q <= 1'b1;
              len_q        <= len_d;
            end else begin
              state_q <= DROP;
            end
          end
        end

        DROP: begin
          if (!bus.phy_rx_dv) begin
            state_q   <= IDLE;
            discard_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.r_data_out    = data_q;
  assign bus.r_data_valid  = data_valid_q;
  assign bus.r_ctrl_out    = ctrl_q;
  assign bus.r_frame_valid = frame_valid_q;
  assign bus.r_discard_en  = discard_q;

endmodule

// File: tb/tb_recv_phy_deframer.sv
// -----------------------------------------------------------------------------
// tb_recv_phy_deframer
// Drives nibble frames into recv_phy_deframer and compares the byte stream and
// end-of-frame strobes against expectations derived from frame-level rules
// (byte counts, length window, error position, nibble parity, FCS).
// Honours RECV_CRC_CHECK_EN: payloads then carry a real FCS in their last
// four bytes.
// -----------------------------------------------------------------------------
module tb_recv_phy_deframer;

  localparam int LEN_W   = 12;
  localparam int MIN_LEN = 64;
  localparam int MAX_LEN = 2048;

  logic clk_phy = 1'b0;
  logic reset;

  always #5 clk_phy = ~clk_phy;

  recv_phy_deframer_if #(.LEN_W(LEN_W)) bus ();

  recv_phy_deframer #(
    .LEN_W   (LEN_W),
    .MIN_LEN (MIN_LEN),
    .MAX_LEN (MAX_LEN)
  ) dut (
    .clk_phy (clk_phy),
    .reset   (reset),
    .bus     (bus)
  );

  // Scoreboard
  logic [7:0]         tx_q[$];
  logic [7:0]         exp_bytes[$];
  logic [7:0]         got_bytes[$];
  logic [2*LEN_W-1:0] exp_ctrl[$];
  logic [2*LEN_W-1:0] got_ctrl[$];
  int exp_valid   = 0;
  int exp_discard = 0;
  int got_valid   = 0;
  int got_discard = 0;
  int ctrl_leak   = 0;
  int both_set    = 0;
  int n_checks    = 0;
  int n_pass      = 0;

  always @(negedge clk_phy) begin
    if (bus.r_data_valid === 1'b1) got_bytes.push_back(bus.r_data_out);
    if (bus.r_frame_valid === 1'b1) begin
      got_valid++;
      got_ctrl.push_back(bus.r_ctrl_out);
    end
    if (bus.r_discard_en === 1'b1) got_discard++;
    if (bus.r_frame_valid !== 1'b1 && bus.r_ctrl_out !== '0) ctrl_leak++;
    if (bus.r_frame_valid === 1'b1 && bus.r_discard_en === 1'b1) both_set++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  // Reference CRC-32 over tx_q[0 .. m-1]; returns the FCS value.
  function automatic logic [31:0] fcs_of(input int m);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < m; i++) begin
      c = c ^ {24'h0, tx_q[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic bit fcs_ok();
    int m;
    m = tx_q.size() - 4;
    if (m < 0) return 1'b0;
    return fcs_of(m) == {tx_q[m+3], tx_q[m+2], tx_q[m+1], tx_q[m]};
  endfunction

  // Fills tx_q with n bytes (counting or random); with CRC enabled the last
  // four bytes are replaced by the FCS so the total length stays n.
  function automatic void build_payload(input int n, input bit counting);
    logic [31:0] f;
    tx_q.delete();
    for (int i = 0; i < n; i++) tx_q.push_back(counting ? 8'(i) : 8'($urandom));
`ifdef RECV_CRC_CHECK_EN
    if (n >= 4) begin
      repeat (4) void'(tx_q.pop_back());
      f = fcs_of(n - 4);
      for (int k = 0; k < 4; k++) tx_q.push_back(f[8*k +: 8]);
    end
`endif
  endfunction

  function automatic int byte_diffs();
    int d;
    d = 0;
    if (got_bytes.size() != exp_bytes.size()) return -1;
    foreach (exp_bytes[i]) if (got_bytes[i] !== exp_bytes[i]) d++;
    return d;
  endfunction

  function automatic int ctrl_diffs();
    int d;
    d = 0;
    if (got_ctrl.size() != exp_ctrl.size()) return -1;
    foreach (exp_ctrl[i]) if (got_ctrl[i] !== exp_ctrl[i]) d++;
    return d;
  endfunction

  // Sends tx_q as one frame and records the expected outcome.
  //   n_pre   preamble nibbles (0: frame starts with SFD, i.e. a bad start)
  //   odd_nib append one stray nibble
  //   er_nib  data-nibble index carrying rx_er (-1: none)
  //   rst_nib data-nibble index during which reset is low (-1: none)
  //   gap     idle cycles after the frame
  task automatic send_frame(input int n_pre, input bit odd_nib, input int er_nib,
                            input int rst_nib, input int gap, output bit rst_zero);
    logic [3:0] nibs[$];
    int n, done, off, d;
    bit bad;
    n        = tx_q.size();
    rst_zero = 1'b0;

    // Expected outcome from frame-level rules.
    done = n;
    bad  = 1'b0;
    if (n_pre == 0) begin done = 0; bad = 1'b1; end
    if (er_nib >= 0) begin
      if (er_nib / 2 < done) done = er_nib / 2;
      bad = 1'b1;
    end
    if (done > MAX_LEN) begin done = MAX_LEN; bad = 1'b1; end
    if (n > MAX_LEN) bad = 1'b1;
    if (odd_nib) bad = 1'b1;
    if (n < MIN_LEN) bad = 1'b1;
`ifdef RECV_CRC_CHECK_EN
    if (!fcs_ok()) bad = 1'b1;
`endif
    if (rst_nib >= 0) begin
      if (rst_nib / 2 < done) done = rst_nib / 2;
    end else if (bad) begin
      exp_discard++;
    end else begin
      exp_valid++;
      exp_ctrl.push_back({LEN_W'(n), LEN_W'(n)});
    end
    for (int k = 0; k < done; k++) exp_bytes.push_back(tx_q[k]);

    // Stimulus.
    for (int i = 0; i < n_pre; i++) nibs.push_back(4'h5);
    nibs.push_back(4'hD);
    off = nibs.size();
    foreach (tx_q[i]) begin
      nibs.push_back(tx_q[i][3:0]);
      nibs.push_back(tx_q[i][7:4]);
    end
    if (odd_nib) nibs.push_back(4'($urandom));

    foreach (nibs[i]) begin
      d = i - off;
      bus.phy_rx_dv   = 1'b1;
      bus.phy_data_in = nibs[i];
      bus.phy_rx_er   = (er_nib >= 0) && (d == er_nib);
      reset           = !((rst_nib >= 0) && (d == rst_nib));
      @(posedge clk_phy);
      #1;
      if ((rst_nib >= 0) && (d == rst_nib)) begin
        rst_zero = (bus.r_data_valid === 1'b0) && (bus.r_frame_valid === 1'b0) &&
                   (bus.r_discard_en === 1'b0) && (bus.r_ctrl_out === '0) &&
                   (bus.r_data_out === 8'h00);
      end
    end
    bus.phy_rx_dv   = 1'b0;
    bus.phy_rx_er   = 1'b0;
    bus.phy_data_in = 4'h0;
    reset           = 1'b1;
    repeat (gap) begin
      @(posedge clk_phy);
      #1;
    end
  endtask

  task automatic test_reset();
    reset           = 1'b0;
    bus.phy_rx_dv   = 1'b0;
    bus.phy_rx_er   = 1'b0;
    bus.phy_data_in = 4'h0;
    repeat (3) @(posedge clk_phy);
    #1;
    n_checks++; if (bus.r_data_valid !== 1'b0) $display("FAIL reset_data_valid: got %b expected 0", bus.r_data_valid); else n_pass++;
    n_checks++; if (bus.r_frame_valid !== 1'b0) $display("FAIL reset_frame_valid: got %b expected 0", bus.r_frame_valid); else n_pass++;
    n_checks++; if (bus.r_discard_en !== 1'b0) $display("FAIL reset_discard: got %b expected 0", bus.r_discard_en); else n_pass++;
    n_checks++; if (bus.r_ctrl_out !== '0) $display("FAIL reset_ctrl: got %h expected 0", bus.r_ctrl_out); else n_pass++;
    n_checks++; if (bus.r_data_out !== 8'h00) $display("FAIL reset_data: got %h expected 00", bus.r_data_out); else n_pass++;
    reset = 1'b1;
    repeat (2) begin @(posedge clk_phy); #1; end
  endtask

  task automatic test_long_frame();
    bit z;
    build_payload(512, 1'b1);
    send_frame(7, 1'b0, -1, -1, 4, z);
    n_checks++; if (got_bytes.size() != exp_bytes.size()) $display("FAIL long_byte_count: got %0d expected %0d", got_bytes.size(), exp_bytes.size()); else n_pass++;
    n_checks++; if (byte_diffs() != 0) $display("FAIL long_bytes: got %0d differing bytes expected 0", byte_diffs()); else n_pass++;
    n_checks++; if (got_valid != exp_valid) $display("FAIL long_frame_valid: got %0d expected %0d", got_valid, exp_valid); else n_pass++;
    n_checks++; if (got_discard != exp_discard) $display("FAIL long_discard: got %0d expected %0d", got_discard, exp_discard); else n_pass++;
    n_checks++; if (got_ctrl.size() == 0 || got_ctrl[$] !== 24'h200200) $display("FAIL long_ctrl: got %h expected 200200", (got_ctrl.size() == 0) ? 24'h0 : got_ctrl[$]); else n_pass++;
  endtask

  task automatic test_length_bounds();
    bit z;
    build_payload(MIN_LEN, 1'b0);
    send_frame(1 + int'($urandom_range(6)), 1'b0, -1, -1, 3, z);
    n_checks++; if (got_ctrl.size() == 0 || got_ctrl[$] !== 24'h040040) $display("FAIL min_ctrl: got %h expected 040040", (got_ctrl.size() == 0) ? 24'h0 : got_ctrl[$]); else n_pass++;
    build_payload(MIN_LEN - 1, 1'b0);
    send_frame(7, 1'b0, -1, -1, 3, z);
    build_payload(MAX_LEN + 1, 1'b0);
    send_frame(7, 1'b0, -1, -1, 4, z);
    n_checks++; if (got_bytes.size() != exp_bytes.size()) $display("FAIL bounds_byte_count: got %0d expected %0d", got_bytes.size(), exp_bytes.size()); else n_pass++;
    n_checks++; if (byte_diffs() != 0) $display("FAIL bounds_bytes: got %0d differing bytes expected 0", byte_diffs()); else n_pass++;
    n_checks++; if (got_valid != exp_valid) $display("FAIL bounds_frame_valid: got %0d expected %0d", got_valid, exp_valid); else n_pass++;
    n_checks++; if (got_discard != exp_discard) $display("FAIL bounds_discard: got %0d expected %0d", got_discard, exp_discard); else n_pass++;
    n_checks++; if (ctrl_diffs() != 0) $display("FAIL bounds_ctrl: got %0d differing ctrl words expected 0", ctrl_diffs()); else n_pass++;
  endtask

  task automatic test_errors();
    bit z;
    build_payload(200, 1'b0);
    send_frame(7, 1'b0, 200 + int'($urandom_range(1)), -1, 3, z);
    build_payload(64, 1'b0);
    send_frame(7, 1'b1, -1, -1, 3, z);
    build_payload(80, 1'b0);
    send_frame(0, 1'b0, -1, -1, 4, z);
    n_checks++; if (got_bytes.size() != exp_bytes.size()) $display("FAIL err_byte_count: got %0d expected %0d", got_bytes.size(), exp_bytes.size()); else n_pass++;
    n_checks++; if (byte_diffs() != 0) $display("FAIL err_bytes: got %0d differing bytes expected 0", byte_diffs()); else n_pass++;
    n_checks++; if (got_valid != exp_valid) $display("FAIL err_frame_valid: got %0d expected %0d", got_valid, exp_valid); else n_pass++;
    n_checks++; if (got_discard != exp_discard) $display("FAIL err_discard: got %0d expected %0d", got_discard, exp_discard); else n_pass++;
  endtask

  task automatic test_mid_reset();
    bit z;
    build_payload(400, 1'b0);
    send_frame(7, 1'b0, -1, 600, 3, z);
    n_checks++; if (z !== 1'b1) $display("FAIL midreset_outputs: got %b expected 1 (all outputs zero)", z); else n_pass++;
    build_payload(MIN_LEN, 1'b0);
    send_frame(7, 1'b0, -1, -1, 4, z);
    n_checks++; if (got_ctrl.size() == 0 || got_ctrl[$] !== 24'h040040) $display("FAIL midreset_ctrl: got %h expected 040040", (got_ctrl.size() == 0) ? 24'h0 : got_ctrl[$]); else n_pass++;
    n_checks++; if (got_bytes.size() != exp_bytes.size()) $display("FAIL midreset_byte_count: got %0d expected %0d", got_bytes.size(), exp_bytes.size()); else n_pass++;
    n_checks++; if (byte_diffs() != 0) $display("FAIL midreset_bytes: got %0d differing bytes expected 0", byte_diffs()); else n_pass++;
    n_checks++; if (got_valid != exp_valid) $display("FAIL midreset_frame_valid: got %0d expected %0d", got_valid, exp_valid); else n_pass++;
    n_checks++; if (got_discard != exp_discard) $display("FAIL midreset_discard: got %0d expected %0d", got_discard, exp_discard); else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit z;
    int v0;
`ifdef RECV_CRC_CHECK_EN
    build_payload(96, 1'b0);
    send_frame(7, 1'b0, -1, -1, 3, z);
    build_payload(96, 1'b0);
    tx_q[10] = tx_q[10] ^ (8'h1 << $urandom_range(7));
    send_frame(7, 1'b0, -1, -1, 3, z);
`endif
    v0 = got_valid;
    build_payload(64 + int'($urandom_range(40)), 1'b0);
    send_frame(7, 1'b0, -1, -1, 1, z);
    build_payload(64 + int'($urandom_range(40)), 1'b0);
    send_frame(7, 1'b0, -1, -1, 4, z);
    n_checks++; if (got_valid - v0 != 2) $display("FAIL b2b_pulses: got %0d expected 2", got_valid - v0); else n_pass++;
    n_checks++; if (got_valid != exp_valid) $display("FAIL b2b_frame_valid: got %0d expected %0d", got_valid, exp_valid); else n_pass++;
    n_checks++; if (got_discard != exp_discard) $display("FAIL b2b_discard: got %0d expected %0d", got_discard, exp_discard); else n_pass++;
    n_checks++; if (ctrl_diffs() != 0) $display("FAIL b2b_ctrl: got %0d differing ctrl words expected 0", ctrl_diffs()); else n_pass++;
    n_checks++; if (byte_diffs() != 0) $display("FAIL b2b_bytes: got %0d differing bytes expected 0", byte_diffs()); else n_pass++;
  endtask

  task automatic test_random();
    bit z;
    int n, er;
    for (int f = 0; f < 8; f++) begin
      n  = 40 + int'($urandom_range(110));
      er = ($urandom_range(3) == 0) ? int'($urandom_range(2 * n - 1)) : -1;
      build_payload(n, 1'b0);
      send_frame(1 + int'($urandom_range(6)), ($urandom_range(4) == 0), er, -1,
                 (f == 7) ? 4 : 1 + int'($urandom_range(2)), z);
    end
    n_checks++; if (got_bytes.size() != exp_bytes.size()) $display("FAIL rand_byte_count: got %0d expected %0d", got_bytes.size(), exp_bytes.size()); else n_pass++;
    n_checks++; if (byte_diffs() != 0) $display("FAIL rand_bytes: got %0d differing bytes expected 0", byte_diffs()); else n_pass++;
    n_checks++; if (got_valid != exp_valid) $display("FAIL rand_frame_valid: got %0d expected %0d", got_valid, exp_valid); else n_pass++;
    n_checks++; if (got_discard != exp_discard) $display("FAIL rand_discard: got %0d expected %0d", got_discard, exp_discard); else n_pass++;
    n_checks++; if (ctrl_diffs() != 0) $display("FAIL rand_ctrl: got %0d differing ctrl words expected 0", ctrl_diffs()); else n_pass++;
  endtask

  task automatic test_invariants();
    n_checks++; if (ctrl_leak != 0) $display("FAIL ctrl_without_valid: got %0d cycles expected 0", ctrl_leak); else n_pass++;
    n_checks++; if (both_set != 0) $display("FAIL valid_and_discard: got %0d cycles expected 0", both_set); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_long_frame();
    test_length_bounds();
    test_errors();
    test_mid_reset();
    test_back_to_back();
    test_random();
    test_invariants();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
